cdb_arbiter: RTL

Common-data-bus arbiter for the Qu out-of-order core. It collects completed results from N_REQ execution units (ALU, load unit, branch/jump unit, …) into per-unit one-entry holding slots. It grants one slot per cycle in round-robin order and broadcasts the winner on a registered CDB. The reservation stations, ROB and physical register file consume that broadcast. A branch-mispredict flush squashes all held and in-flight results.

---
 rtl/cdb_arbiter_if.sv | 44 ++++
 rtl/cdb_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// ============================================================================
//  Module      : cdb_arbiter_if
//  Description : Execution-unit result offers and the registered CDB broadcast.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cdb_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ROB_AW = 3,
    parameter int PRF_AW = 7,
    parameter int DW     = 32
);
    logic                     flush;
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*ROB_AW-1:0]  req_rob_addr;
    logic [N_REQ*PRF_AW-1:0]  req_dest;
    logic [N_REQ-1:0]         req_dest_valid;
    logic [N_REQ*DW-1:0]      req_value;

    logic                     cdb_valid;
    logic [N_REQ-1:0]         cdb_grant;
    logic [ROB_AW-1:0]        cdb_rob_addr;
    logic [PRF_AW-1:0]        cdb_dest;
    logic                     cdb_dest_valid;
    logic [DW-1:0]            cdb_value;

    // Execution units / pipeline control side
    modport master (
        output flush, req_valid, req_rob_addr, req_dest, req_dest_valid, req_value,
        input  req_ready,
        input  cdb_valid, cdb_grant, cdb_rob_addr, cdb_dest, cdb_dest_valid, cdb_value
    );

    // Arbiter side
    modport slave (
        input  flush, req_valid, req_rob_addr, req_dest, req_dest_valid, req_value,
        output req_ready,
        output cdb_valid, cdb_grant, cdb_rob_addr, cdb_dest, cdb_dest_valid, cdb_value
    );
endinterface

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Round-robin common-data-bus arbiter with per-unit holding
//                slots, registered broadcast and mispredict flush.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ROB_AW = 3,
    parameter int PRF_AW = 7,
    parameter int DW     = 32
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  full_q, full_d;
    logic [ROB_AW-1:0] rob_q   [N_REQ];
    logic [PRF_AW-1:0] dest_q  [N_REQ];
    logic              dvld_q  [N_REQ];
    logic [DW-1:0]     value_q [N_REQ];

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic              cdb_valid_q;
    logic [N_REQ-1:0]  cdb_grant_q;
    logic [ROB_AW-1:0] cdb_rob_q;
    logic [PRF_AW-1:0] cdb_dest_q;
    logic              cdb_dvld_q;
    logic [DW-1:0]     cdb_value_q;

    logic              found;
    logic              grant_any;
    logic [PTR_W-1:0]  gnt_idx;
    logic [N_REQ-1:0]  grant;
    logic [N_REQ-1:0]  ready;
    logic [N_REQ-1:0]  accept;

    logic [ROB_AW-1:0] sel_rob;
    logic [PRF_AW-1:0] sel_dest;
    logic              sel_dvld;
    logic [DW-1:0]     sel_value;

    // Search full slots starting at rr_ptr; the first hit (modulo N_REQ) wins.
    always_comb begin
        int  s;
        logic cand;
        s       = 0;
        cand    = 1'b0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int off = 0; off < N_REQ; off++) begin
            s = int'(rr_ptr_q) + off;
            if (s >= N_REQ) begin
                s = s - N_REQ;
            end
            cand = 1'b0;
            for (int j = 0; j < N_REQ; j++) begin
                if (j == s) begin
                    cand = full_q[j];
                end
            end
            if (!found && cand) begin
                found   = 1'b1;
                gnt_idx = PTR_W'(s);
            end
        end
    end

    assign grant_any = found && !bus.flush && !rst;

    always_comb begin
        grant  = '0;
        ready  = '0;
        accept = '0;
        full_d = full_q;
        for (int j = 0; j < N_REQ; j++) begin
            grant[j]  = grant_any && (gnt_idx == PTR_W'(j));
            ready[j]  = !rst && !bus.flush && (!full_q[j] || grant[j]);
            accept[j] = bus.req_valid[j] && ready[j];
            if (bus.flush) begin
                full_d[j] = 1'b0;
            end else if (accept[j]) begin
                full_d[j] = 1'b1;
            end else if (grant[j]) begin
                full_d[j] = 1'b0;
            end
        end
    end

    always_comb begin
        sel_rob   = '0;
        sel_dest  = '0;
        sel_dvld  = 1'b0;
        sel_value = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (grant[j]) begin
                sel_rob   = rob_q[j];
                sel_dest  = dest_q[j];
                sel_dvld  = dvld_q[j];
                sel_value = value_q[j];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            if (gnt_idx == PTR_W'(N_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx + PTR_W'(1);
            end
        end
    end

    // Slot state and payload capture
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= '0;
            for (int j = 0; j < N_REQ; j++) begin
                rob_q[j]   <= '0;
                dest_q[j]  <= '0;
                dvld_q[j]  <= 1'b0;
                value_q[j] <= '0;
            end
        end else begin
            full_q <= full_d;
            for (int j = 0; j < N_REQ; j++) begin
                if (accept[j]) begin
                    rob_q[j]   <= bus.req_rob_addr[j*ROB_AW +: ROB_AW];
                    dest_q[j]  <= bus.req_dest[j*PRF_AW +: PRF_AW];
                    dvld_q[j]  <= bus.req_dest_valid[j];
                    value_q[j] <= bus.req_value[j*DW +: DW];
                end
            end
        end
    end

    // Broadcast register; payload holds when no beat is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_grant_q <= '0;
            cdb_rob_q   <= '0;
            cdb_dest_q  <= '0;
            cdb_dvld_q  <= 1'b0;
            cdb_value_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= grant_any;
            cdb_grant_q <= grant;
            if (grant_any) begin
                cdb_rob_q   <= sel_rob;
                cdb_dest_q  <= sel_dest;
                cdb_dvld_q  <= sel_dvld;
                cdb_value_q <= sel_value;
            end
        end
    end

    assign bus.req_ready      = ready;
    assign bus.cdb_valid      = cdb_valid_q;
    assign bus.cdb_grant      = cdb_grant_q;
    assign bus.cdb_rob_addr   = cdb_rob_q;
    assign bus.cdb_dest       = cdb_dest_q;
    assign bus.cdb_dest_valid = cdb_dvld_q;
    assign bus.cdb_value      = cdb_value_q;

endmodule

`default_nettype wire
